set_job_arbiter: RTL and testbench

//  Shares one SET set-counting engine between N_REQ requesters. Each requester posts a job (central, radius, mode).

---
 rtl/set_job_arbiter_pkg.sv | 21 ++
 rtl/set_job_arbiter_rr.sv | 52 +++++
 rtl/set_job_arbiter.sv | 163 ++++++++++++++++
 tb/tb_set_job_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_job_arbiter_pkg.sv
// Shared widths, SET mode encodings and arbiter state type for set_job_arbiter.
package set_job_arbiter_pkg;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int MODE_W    = 2;
  localparam int CAND_W    = 8;

  localparam logic [MODE_W-1:0] MODE_A      = 2'b00;
  localparam logic [MODE_W-1:0] MODE_A_OR_B = 2'b01;
  localparam logic [MODE_W-1:0] MODE_A_SUB  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_A_AND  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/set_job_arbiter_rr.sv
// Round-robin picker: first requesting index after the last served id, wrapping.
// Holds the last-served pointer; grant outputs are purely combinational.
module set_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_update,
  input  logic [ID_W-1:0]  i_upd_id,
  output logic             o_any,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_gnt_id
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_sum;
  logic            w_any;
  logic [ID_W-1:0] w_gnt_id;
  logic [N_REQ-1:0] w_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= ID_W'(N_REQ - 1);
    end else if (i_update) begin
      r_ptr <= i_upd_id;
    end
  end

  // Scan ptr+1 .. ptr+N_REQ so the last served requester has lowest priority.
  always_comb begin
    w_sum    = '0;
    w_any    = 1'b0;
    w_gnt_id = '0;
    w_gnt    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) w_sum = w_sum - (ID_W+1)'(N_REQ);
      if (!w_any && i_req[w_sum[ID_W-1:0]]) begin
        w_any    = 1'b1;
        w_gnt_id = w_sum[ID_W-1:0];
      end
    end
    w_gnt[w_gnt_id] = w_any;
  end

  assign o_any    = w_any;
  assign o_gnt    = w_gnt;
  assign o_gnt_id = w_gnt_id;

endmodule

// File: rtl/set_job_arbiter.sv
// Shares one SET engine between N_REQ requesters: RR grant, en/busy issue, tagged result.
// Optional watchdog on the WAIT state is enabled by defining SET_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no job outstanding; grant the RR winner and capture its operands
// ISSUE | job captured; pulse set_en as soon as SET is not busy
// WAIT  | job running in SET; wait for set_valid (or watchdog expiry)
// DONE  | result presented for one cycle; RR pointer moves to this id
module set_job_arbiter
  import set_job_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
`ifdef SET_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*CENTRAL_W-1:0] req_central,
  input  logic [N_REQ*RADIUS_W-1:0]  req_radius,
  input  logic [N_REQ*MODE_W-1:0]    req_mode,
  output logic [N_REQ-1:0]           ack,
  output logic                       set_en,
  output logic [CENTRAL_W-1:0]       set_central,
  output logic [RADIUS_W-1:0]        set_radius,
  output logic [MODE_W-1:0]          set_mode,
  input  logic                       set_busy,
  input  logic                       set_valid,
  input  logic [CAND_W-1:0]          set_candidate,
  output logic                       res_valid,
  output logic [ID_W-1:0]            res_id,
  output logic [CAND_W-1:0]          res_candidate,
  output logic                       res_err,
  output logic                       arb_busy
);

  arb_state_e        r_state;
  logic [N_REQ-1:0]  r_ack;
  logic              r_set_en;
  logic [CENTRAL_W-1:0] r_set_central;
  logic [RADIUS_W-1:0]  r_set_radius;
  logic [MODE_W-1:0]    r_set_mode;
  logic              r_res_valid;
  logic [ID_W-1:0]   r_res_id;
  logic [CAND_W-1:0] r_res_candidate;
  logic              r_arb_busy;
  logic [ID_W-1:0]   r_id;

  logic              w_any;
  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_rr_update;

  // Arbitration only matters in IDLE; elsewhere the grant is simply not consumed.
  set_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (req),
    .i_update (w_rr_update),
    .i_upd_id (r_id),
    .o_any    (w_any),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  assign w_rr_update = (r_state == S_DONE);

`ifdef SET_ARB_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMO_W-1:0] r_tmo;
  logic             r_res_err;
  assign res_err = r_res_err;
`else
  assign res_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_ack           <= '0;
      r_set_en        <= 1'b0;
      r_set_central   <= '0;
      r_set_radius    <= '0;
      r_set_mode      <= '0;
      r_res_valid     <= 1'b0;
      r_res_id        <= '0;
      r_res_candidate <= '0;
      r_arb_busy      <= 1'b0;
      r_id            <= '0;
`ifdef SET_ARB_TIMEOUT_EN
      r_tmo           <= '0;
      r_res_err       <= 1'b0;
`endif
    end else begin
      r_ack       <= '0;
      r_set_en    <= 1'b0;
      r_res_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_set_central <= req_central[w_gnt_id*CENTRAL_W +: CENTRAL_W];
            r_set_radius  <= req_radius[w_gnt_id*RADIUS_W +: RADIUS_W];
            r_set_mode    <= req_mode[w_gnt_id*MODE_W +: MODE_W];
            r_ack         <= w_gnt;
            r_id          <= w_gnt_id;
            r_arb_busy    <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!set_busy) begin
            r_set_en <= 1'b1;
            r_state  <= S_WAIT;
`ifdef SET_ARB_TIMEOUT_EN
            r_tmo    <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (set_valid) begin
            r_res_valid     <= 1'b1;
            r_res_id        <= r_id;
            r_res_candidate <= set_candidate;
            r_state         <= S_DONE;
`ifdef SET_ARB_TIMEOUT_EN
            r_res_err       <= 1'b0;
          end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            r_res_valid     <= 1'b1;
            r_res_id        <= r_id;
            r_res_candidate <= '0;
            r_res_err       <= 1'b1;
            r_state         <= S_DONE;
          end else if (!r_set_en) begin
            // Counting starts the cycle after the set_en pulse.
            r_tmo <= r_tmo + TMO_W'(1);
`endif
          end
        end
        S_DONE: begin
          r_arb_busy <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack           = r_ack;
  assign set_en        = r_set_en;
  assign set_central   = r_set_central;
  assign set_radius    = r_set_radius;
  assign set_mode      = r_set_mode;
  assign res_valid     = r_res_valid;
  assign res_id        = r_res_id;
  assign res_candidate = r_res_candidate;
  assign arb_busy      = r_arb_busy;

endmodule

// File: tb/tb_set_job_arbiter.sv
// Self-checking bench for set_job_arbiter: directed scenarios plus randomized jobs
// against a round-robin / SET point-count reference model.
module tb_set_job_arbiter;

  localparam int N = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*24-1:0] req_central = '0;
  logic [N*12-1:0] req_radius = '0;
  logic [N*2-1:0]  req_mode = '0;
  logic [N-1:0]    ack;
  logic            set_en;
  logic [23:0]     set_central;
  logic [11:0]     set_radius;
  logic [1:0]      set_mode;
  logic            set_busy = 1'b0;
  logic            set_valid = 1'b0;
  logic [7:0]      set_candidate = '0;
  logic            res_valid;
  logic [IW-1:0]   res_id;
  logic [7:0]      res_candidate;
  logic            res_err;
  logic            arb_busy;

  int n_checks = 0;
  int n_errors = 0;
  int last_id  = N - 1;
  int pend_idx = -1;

  set_job_arbiter #(
    .N_REQ (N),
    .ID_W  (IW)
`ifdef SET_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_central   (req_central),
    .req_radius    (req_radius),
    .req_mode      (req_mode),
    .ack           (ack),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_candidate (res_candidate),
    .res_err       (res_err),
    .arb_busy      (arb_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SET engine model: lattice points (1..8, 1..8) inside circles A and B combined by mode.
  function automatic int set_count(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int cnt;
    int x1, y1, x2, y2, r1, r2;
    bit in_a, in_b, hit;
    x1 = int'(c[23:20]); y1 = int'(c[19:16]);
    x2 = int'(c[15:12]); y2 = int'(c[11:8]);
    r1 = int'(r[11:8]);  r2 = int'(r[7:4]);
    cnt = 0;
    for (int x = 1; x <= 8; x++) begin
      for (int y = 1; y <= 8; y++) begin
        in_a = ((x-x1)*(x-x1) + (y-y1)*(y-y1)) <= r1*r1;
        in_b = ((x-x2)*(x-x2) + (y-y2)*(y-y2)) <= r2*r2;
        case (m)
          2'b00:   hit = in_a;
          2'b01:   hit = in_a || in_b;
          2'b10:   hit = in_a && !in_b;
          default: hit = in_a && in_b;
        endcase
        if (hit) cnt++;
      end
    end
    return cnt;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    set_busy = 1'b0;
    set_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    last_id = N - 1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},      32'(ack), 0);
    chk({tag, "_set_en"},   32'(set_en), 0);
    chk({tag, "_central"},  32'(set_central), 0);
    chk({tag, "_radius"},   32'(set_radius), 0);
    chk({tag, "_mode"},     32'(set_mode), 0);
    chk({tag, "_res_v"},    32'(res_valid), 0);
    chk({tag, "_res_id"},   32'(res_id), 0);
    chk({tag, "_res_cand"}, 32'(res_candidate), 0);
    chk({tag, "_res_err"},  32'(res_err), 0);
    chk({tag, "_busy"},     32'(arb_busy), 0);
  endtask

  task automatic rand_slot(input int i);
    req_central[24*i +: 24] = 24'($urandom);
    req_radius[12*i +: 12]  = 12'($urandom);
    req_mode[2*i +: 2]      = 2'($urandom);
  endtask

  // Called in an IDLE cycle with req already presented; returns in the next IDLE cycle.
  task automatic run_job(input int exp_id, input int busy_cyc, input int lat, input bit drop);
    logic [23:0] c;
    logic [11:0] r;
    logic [1:0]  m;
    int cand, n;
    c = req_central[24*exp_id +: 24];
    r = req_radius[12*exp_id +: 12];
    m = req_mode[2*exp_id +: 2];
    cand = set_count(c, r, m);
    n = 0;
    do begin tick(); n++; end while (ack == '0 && n < 20);
    chk("ack_latency", 32'(n), 1);
    chk("ack_onehot", 32'(ack), 32'(1) << exp_id);
    chk("arb_busy_on", 32'(arb_busy), 1);
    chk("cap_central", 32'(set_central), 32'(c));
    chk("cap_radius", 32'(set_radius), 32'(r));
    chk("cap_mode", 32'(set_mode), 32'(m));
    if (drop) req[exp_id] = 1'b0;
    req_central[24*exp_id +: 24] = ~c;
    req_radius[12*exp_id +: 12]  = ~r;
    req_mode[2*exp_id +: 2]      = ~m;
    if (busy_cyc > 0) begin
      set_busy = 1'b1;
      for (int i = 0; i < busy_cyc; i++) begin
        tick();
        chk("en_held_busy", 32'(set_en), 0);
        chk("ack_pulse", 32'(ack), 0);
      end
      set_busy = 1'b0;
    end
    tick();
    chk("set_en_pulse", 32'(set_en), 1);
    chk("hold_central", 32'(set_central), 32'(c));
    chk("hold_radius", 32'(set_radius), 32'(r));
    chk("hold_mode", 32'(set_mode), 32'(m));
    for (int i = 0; i < lat; i++) begin
      if (i == 0 && pend_idx >= 0) begin
        req[pend_idx] = 1'b1;
        pend_idx = -1;
      end
      tick();
      chk("set_en_once", 32'(set_en), 0);
      chk("no_ack_in_wait", 32'(ack), 0);
      chk("no_early_res", 32'(res_valid), 0);
    end
    set_valid = 1'b1;
    set_candidate = 8'(cand);
    tick();
    set_valid = 1'b0;
    set_candidate = 8'($urandom);
    chk("res_valid", 32'(res_valid), 1);
    chk("res_id", 32'(res_id), 32'(exp_id));
    chk("res_cand", 32'(res_candidate), 32'(cand));
    chk("res_err", 32'(res_err), 0);
    chk("no_ack_done", 32'(ack), 0);
    tick();
    chk("res_pulse", 32'(res_valid), 0);
    chk("arb_busy_off", 32'(arb_busy), 0);
    last_id = exp_id;
  endtask

  initial begin
    int e, n;
    for (int i = 0; i < N; i++) rand_slot(i);

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // Single job with known point count (29)
    req_central[23:0] = 24'h440000;
    req_radius[11:0]  = 12'h300;
    req_mode[1:0]     = 2'b00;
    chk("model_cand29", 32'(set_count(24'h440000, 12'h300, 2'b00)), 29);
    req = 4'b0001;
    run_job(0, 0, 3, 1'b1);

    // All requesters held: 0,1,2,3,0 after a fresh reset
    do_reset();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      e = rr_pick(req, last_id);
      chk("rr_order", 32'(e), 32'(j % N));
      run_job(e, 0, 1 + j, 1'b0);
    end
    req = '0;

    // req[2] raised while job for 0 is in WAIT
    rand_slot(0);
    rand_slot(2);
    req = 4'b0001;
    pend_idx = 2;
    run_job(0, 0, 6, 1'b1);
    run_job(rr_pick(req, last_id), 0, 2, 1'b1);

    // SET busy for 20 cycles in ISSUE
    rand_slot(3);
    req = 4'b1000;
    run_job(3, 20, 2, 1'b1);

    // Reset in WAIT, late set_valid ignored, RR restarts at 0
    rand_slot(2);
    req = 4'b0100;
    tick();
    chk("t5_ack", 32'(ack), 32'b0100);
    req = '0;
    tick();
    chk("t5_set_en", 32'(set_en), 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_id = N - 1;
    chk_all_zero("midrst");
    set_valid = 1'b1;
    set_candidate = 8'd42;
    tick();
    set_valid = 1'b0;
    chk("late_valid_ign", 32'(res_valid), 0);
    tick();
    chk("late_valid_ign2", 32'(res_valid), 0);
    rand_slot(0);
    rand_slot(1);
    req = 4'b0011;
    e = rr_pick(req, last_id);
    chk("rr_restart", 32'(e), 0);
    run_job(e, 0, 1, 1'b1);
    run_job(rr_pick(req, last_id), 1, 0, 1'b1);

`ifdef SET_ARB_TIMEOUT_EN
    // Watchdog: SET never answers
    rand_slot(0);
    req = 4'b0001;
    tick();
    chk("tmo_ack", 32'(ack), 1);
    req = '0;
    tick();
    chk("tmo_set_en", 32'(set_en), 1);
    n = 0;
    while (!res_valid && n < 40) begin tick(); n++; end
    chk("tmo_latency", 32'(n), 17);
    chk("tmo_err", 32'(res_err), 1);
    chk("tmo_cand", 32'(res_candidate), 0);
    chk("tmo_id", 32'(res_id), 0);
    tick();
    last_id = 0;
    set_valid = 1'b1;
    tick();
    set_valid = 1'b0;
    chk("tmo_late_valid", 32'(res_valid), 0);
    rand_slot(1);
    req = 4'b0011;
    rand_slot(0);
    e = rr_pick(req, last_id);
    chk("tmo_rr_adv", 32'(e), 1);
    run_job(e, 0, 2, 1'b1);
`endif

    // Randomized jobs
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          rand_slot(i);
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        rand_slot(j % N);
        req[j % N] = 1'b1;
      end
      e = rr_pick(req, last_id);
      run_job(e, $urandom_range(0, 3), $urandom_range(0, 5), 1'b1);
    end
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
